// File: rtl/datapath_sequencer_pkg.sv
// Shared types and select encodings for the stepper ASIP sequencer.
// Imported by the sequencer interface and the sequencer itself.
package seq_pkg;

    typedef enum logic [2:0] {
        FETCH    = 3'd0,
        EXEC     = 3'd1,
        WAIT_P   = 3'd2,
        MV_CHECK = 3'd3,
        MV_STEP  = 3'd4,
        MV_WAIT  = 3'd5
    } state_t;

    localparam logic [1:0] OP1_PC    = 2'd0;
    localparam logic [1:0] OP1_SEL0  = 2'd1;
    localparam logic [1:0] OP1_R0    = 2'd2;
    localparam logic [1:0] OP1_POS   = 2'd3;

    localparam logic [1:0] OP2_SEL1  = 2'd0;
    localparam logic [1:0] OP2_IMM   = 2'd1;

    localparam logic [1:0] IMM_BR    = 2'd0;
    localparam logic [1:0] IMM_U3    = 2'd1;
    localparam logic [1:0] IMM_NIB   = 2'd2;
    localparam logic [1:0] IMM_ONE   = 2'd3;

    localparam logic [1:0] WADDR_F0  = 2'd0;
    localparam logic [1:0] WADDR_F1  = 2'd1;
    localparam logic [1:0] WADDR_POS = 2'd2;
    localparam logic [1:0] WADDR_R0  = 2'd3;

    localparam logic [1:0] POSITION_ADDR = 2'd2;
    localparam logic [1:0] R0_ADDR       = 2'd0;

    localparam int D_BR     = 11;
    localparam int D_BRZ    = 10;
    localparam int D_ADDI   = 9;
    localparam int D_SUBI   = 8;
    localparam int D_SR0    = 7;
    localparam int D_SRH0   = 6;
    localparam int D_CLR    = 5;
    localparam int D_MOV    = 4;
    localparam int D_MOVA   = 3;
    localparam int D_MOVR   = 2;
    localparam int D_MOVRHS = 1;
    localparam int D_PAUSE  = 0;

    localparam int T_POS  = 2;
    localparam int T_NEG  = 1;
    localparam int T_ZERO = 0;

endpackage

// File: rtl/datapath_sequencer_if.sv
// Control bundle between the sequencer and the ASIP datapath.
// master = sequencer side, slave = datapath side.
interface datapath_sequencer_if;
    logic [11:0] decoded;
    logic        register0_is_zero;
    logic [2:0]  temp_flags;
    logic        delay_done;

    logic        write_reg_file;
    logic        result_mux_select;
    logic [1:0]  op1_mux_select;
    logic [1:0]  op2_mux_select;
    logic        alu_add_sub;
    logic        alu_set_low;
    logic        alu_set_high;
    logic [1:0]  select_immediate;
    logic [1:0]  select_write_address;
    logic        commit_branch;
    logic        increment_pc;
    logic        load_temp;
    logic        increment_temp;
    logic        decrement_temp;
    logic        start_delay_counter;
    logic        enable_delay_counter;
    logic [2:0]  state_dbg;

    modport master (
        input  decoded, register0_is_zero, temp_flags, delay_done,
        output write_reg_file, result_mux_select,
        output op1_mux_select, op2_mux_select,
        output alu_add_sub, alu_set_low, alu_set_high,
        output select_immediate, select_write_address,
        output commit_branch, increment_pc,
        output load_temp, increment_temp, decrement_temp,
        output start_delay_counter, enable_delay_counter,
        output state_dbg
    );

    modport slave (
        output decoded, register0_is_zero, temp_flags, delay_done,
        input  write_reg_file, result_mux_select,
        input  op1_mux_select, op2_mux_select,
        input  alu_add_sub, alu_set_low, alu_set_high,
        input  select_immediate, select_write_address,
        input  commit_branch, increment_pc,
        input  load_temp, increment_temp, decrement_temp,
        input  start_delay_counter, enable_delay_counter,
        input  state_dbg
    );
endinterface

// File: rtl/datapath_sequencer.sv
// Control FSM for the stepper-motor ASIP datapath.
// Moore outputs plus decoded flags; PC is held during multi-cycle ops.
module datapath_sequencer
    import seq_pkg::*;
#(
    parameter int FETCH_WAIT       = 1,
    parameter int FULL_STEP_WRITES = 2
) (
    input  logic clk,
    input  logic reset_n,
    datapath_sequencer_if.master bus
);

    state_t     state_q, state_d;
    logic [1:0] wait_q;
    logic [1:0] step_q;
    logic       full_q;
    logic       last_write;

    assign last_write    = (step_q <= 2'd1);
    assign bus.state_dbg = state_q;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= FETCH;
        else          state_q <= state_d;
    end

    // Fetch wait counter: reloads whenever FETCH is left or entered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wait_q <= 2'(FETCH_WAIT);
        else if (state_q == FETCH && wait_q > 2'd1)
            wait_q <= wait_q - 2'd1;
        else
            wait_q <= 2'(FETCH_WAIT);
    end

    // Step-write counter and movr/movrhs mode latched at EXEC
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_q <= 2'd0;
            full_q <= 1'b0;
        end else begin
            if (state_q == EXEC)
                full_q <= bus.decoded[D_MOVR];
            if (state_q == MV_CHECK && !bus.temp_flags[T_ZERO])
                step_q <= full_q ? 2'(FULL_STEP_WRITES) : 2'd1;
            else if (state_q == MV_STEP)
                step_q <= step_q - 2'd1;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d                  = state_q;
        bus.write_reg_file       = 1'b0;
        bus.result_mux_select    = 1'b0;
        bus.op1_mux_select       = OP1_PC;
        bus.op2_mux_select       = OP2_SEL1;
        bus.alu_add_sub          = 1'b0;
        bus.alu_set_low          = 1'b0;
        bus.alu_set_high         = 1'b0;
        bus.select_immediate     = IMM_BR;
        bus.select_write_address = WADDR_F0;
        bus.commit_branch        = 1'b0;
        bus.increment_pc         = 1'b0;
        bus.load_temp            = 1'b0;
        bus.increment_temp       = 1'b0;
        bus.decrement_temp       = 1'b0;
        bus.start_delay_counter  = 1'b0;
        bus.enable_delay_counter = 1'b0;

        unique case (state_q)
            FETCH: begin
                if (wait_q <= 2'd1) state_d = EXEC;
            end
            EXEC: begin
                state_d = FETCH;
                if (!$onehot(bus.decoded)) begin
                    bus.increment_pc = 1'b1;
                end else begin
                    unique case (1'b1)
                        bus.decoded[D_ADDI], bus.decoded[D_SUBI]: begin
                            bus.op1_mux_select   = OP1_SEL0;
                            bus.op2_mux_select   = OP2_IMM;
                            bus.select_immediate = IMM_U3;
                            bus.alu_add_sub      = bus.decoded[D_SUBI];
                            bus.write_reg_file   = 1'b1;
                            bus.increment_pc     = 1'b1;
                        end
                        bus.decoded[D_SR0], bus.decoded[D_SRH0]: begin
                            bus.op1_mux_select       = OP1_R0;
                            bus.op2_mux_select       = OP2_IMM;
                            bus.select_immediate     = IMM_NIB;
                            bus.alu_set_low          = bus.decoded[D_SR0];
                            bus.alu_set_high         = bus.decoded[D_SRH0];
                            bus.select_write_address = WADDR_R0;
                            bus.write_reg_file       = 1'b1;
                            bus.increment_pc         = 1'b1;
                        end
                        bus.decoded[D_CLR]: begin
                            bus.result_mux_select = 1'b1;
                            bus.write_reg_file    = 1'b1;
                            bus.increment_pc      = 1'b1;
                        end
                        bus.decoded[D_MOV], bus.decoded[D_MOVA]: begin
                            bus.op2_mux_select = OP2_SEL1;
                            bus.alu_set_low    = 1'b1;
                            bus.alu_set_high   = 1'b1;
                            if (bus.decoded[D_MOVA])
                                bus.select_write_address = WADDR_POS;
                            bus.write_reg_file = 1'b1;
                            bus.increment_pc   = 1'b1;
                        end
                        bus.decoded[D_BR], bus.decoded[D_BRZ]: begin
                            if (bus.decoded[D_BR] || bus.register0_is_zero) begin
                                bus.op1_mux_select   = OP1_PC;
                                bus.op2_mux_select   = OP2_IMM;
                                bus.select_immediate = IMM_BR;
                                bus.commit_branch    = 1'b1;
                            end else begin
                                bus.increment_pc = 1'b1;
                            end
                        end
                        bus.decoded[D_PAUSE]: begin
                            bus.start_delay_counter = 1'b1;
                            state_d = WAIT_P;
                        end
                        bus.decoded[D_MOVR], bus.decoded[D_MOVRHS]: begin
                            bus.load_temp = 1'b1;
                            state_d = MV_CHECK;
                        end
                        default: bus.increment_pc = 1'b1;
                    endcase
                end
            end
            WAIT_P: begin
                bus.enable_delay_counter = 1'b1;
                if (bus.delay_done) begin
                    bus.increment_pc = 1'b1;
                    state_d = FETCH;
                end
            end
            MV_CHECK: begin
                if (bus.temp_flags[T_ZERO]) begin
                    bus.increment_pc = 1'b1;
                    state_d = FETCH;
                end else begin
                    state_d = MV_STEP;
                end
            end
            MV_STEP: begin
                bus.op1_mux_select       = OP1_POS;
                bus.op2_mux_select       = OP2_IMM;
                bus.select_immediate     = IMM_ONE;
                bus.alu_add_sub          = bus.temp_flags[T_NEG];
                bus.select_write_address = WADDR_POS;
                bus.write_reg_file       = 1'b1;
                if (last_write) begin
                    bus.decrement_temp      = bus.temp_flags[T_POS];
                    bus.increment_temp      = bus.temp_flags[T_NEG]
                                              && !bus.temp_flags[T_POS];
                    bus.start_delay_counter = 1'b1;
                    state_d = MV_WAIT;
                end
            end
            MV_WAIT: begin
                bus.enable_delay_counter = 1'b1;
                if (bus.delay_done) state_d = MV_CHECK;
            end
            default: state_d = FETCH;
        endcase
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer.
// Models the temp register sign to drive temp_flags.
module tb_datapath_sequencer;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    int   temp;

    datapath_sequencer_if bus ();

    datapath_sequencer u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_EXEC  = 3'd1;
    localparam logic [2:0] S_WAITP = 3'd2;
    localparam logic [2:0] S_CHK   = 3'd3;
    localparam logic [2:0] S_STEP  = 3'd4;
    localparam logic [2:0] S_MVW   = 3'd5;

    localparam logic [11:0] I_BR     = 12'h800;
    localparam logic [11:0] I_BRZ    = 12'h400;
    localparam logic [11:0] I_ADDI   = 12'h200;
    localparam logic [11:0] I_SUBI   = 12'h100;
    localparam logic [11:0] I_SR0    = 12'h080;
    localparam logic [11:0] I_SRH0   = 12'h040;
    localparam logic [11:0] I_CLR    = 12'h020;
    localparam logic [11:0] I_MOV    = 12'h010;
    localparam logic [11:0] I_MOVA   = 12'h008;
    localparam logic [11:0] I_MOVR   = 12'h004;
    localparam logic [11:0] I_MOVRHS = 12'h002;
    localparam logic [11:0] I_PAUSE  = 12'h001;

    localparam logic [19:0] C_WR  = 20'h80000;
    localparam logic [19:0] C_RES = 20'h40000;
    localparam logic [19:0] C_SUB = 20'h02000;
    localparam logic [19:0] C_SL  = 20'h01000;
    localparam logic [19:0] C_SH  = 20'h00800;
    localparam logic [19:0] C_CB  = 20'h00040;
    localparam logic [19:0] C_IPC = 20'h00020;
    localparam logic [19:0] C_LT  = 20'h00010;
    localparam logic [19:0] C_IT  = 20'h00008;
    localparam logic [19:0] C_DT  = 20'h00004;
    localparam logic [19:0] C_SD  = 20'h00002;
    localparam logic [19:0] C_ED  = 20'h00001;

    // op1 [17:16], op2 [15:14], imm [10:9], waddr [8:7]
    localparam logic [19:0] E_ADDI = C_WR | 20'h10000 | 20'h04000
                                   | 20'h00200 | C_IPC;
    localparam logic [19:0] E_SUBI = E_ADDI | C_SUB;
    localparam logic [19:0] E_SR0  = C_WR | 20'h20000 | 20'h04000
                                   | 20'h00400 | C_SL | 20'h00180 | C_IPC;
    localparam logic [19:0] E_SRH0 = C_WR | 20'h20000 | 20'h04000
                                   | 20'h00400 | C_SH | 20'h00180 | C_IPC;
    localparam logic [19:0] E_CLR  = C_WR | C_RES | C_IPC;
    localparam logic [19:0] E_MOV  = C_WR | C_SL | C_SH | C_IPC;
    localparam logic [19:0] E_MOVA = E_MOV | 20'h00100;
    localparam logic [19:0] E_BR   = 20'h04000 | C_CB;
    localparam logic [19:0] E_STEP = C_WR | 20'h30000 | 20'h04000
                                   | 20'h00600 | 20'h00100;

    wire [19:0] ctrl = {
        bus.write_reg_file, bus.result_mux_select,
        bus.op1_mux_select, bus.op2_mux_select,
        bus.alu_add_sub, bus.alu_set_low, bus.alu_set_high,
        bus.select_immediate, bus.select_write_address,
        bus.commit_branch, bus.increment_pc,
        bus.load_temp, bus.increment_temp, bus.decrement_temp,
        bus.start_delay_counter, bus.enable_delay_counter
    };

    task automatic check(input string tag, input logic [19:0] ec,
                         input logic [2:0] es);
        checks++;
        assert (ctrl === ec) else begin
            errors++;
            $error("FAIL %s ctrl got %h want %h", tag, ctrl, ec);
        end
        checks++;
        assert (bus.state_dbg === es) else begin
            errors++;
            $error("FAIL %s state got %0d want %0d", tag, bus.state_dbg, es);
        end
    endtask

    task automatic set_flags();
        bus.temp_flags = (temp > 0) ? 3'b100 : (temp < 0) ? 3'b010 : 3'b001;
    endtask

    // Starts and ends at a negedge with the DUT in FETCH
    task automatic run_single(input string tag, input logic [11:0] d,
                              input logic r0z, input logic [19:0] ec);
        bus.decoded = d;
        bus.register0_is_zero = r0z;
        #1 check({tag, "_fetch"}, 20'h0, S_FETCH);
        @(negedge clk);
        #1 check(tag, ec, S_EXEC);
        @(negedge clk);
    endtask

    // One step period: MV_CHECK, the writes, two MV_WAIT cycles
    task automatic mv_iter(input string tag, input int writes);
        logic neg;
        logic [19:0] e;
        neg = (temp < 0);
        set_flags();
        bus.delay_done = 1'b1;
        #1 check({tag, "_chk"}, 20'h0, S_CHK);
        @(negedge clk);
        for (int i = 0; i < writes; i++) begin
            set_flags();
            e = E_STEP | (neg ? C_SUB : 20'h0);
            if (i == writes - 1)
                e = e | (neg ? C_IT : C_DT) | C_SD;
            #1 check({tag, "_step"}, e, S_STEP);
            @(negedge clk);
        end
        temp = neg ? temp + 1 : temp - 1;
        set_flags();
        bus.delay_done = 1'b0;
        #1 check({tag, "_wait0"}, C_ED, S_MVW);
        @(negedge clk);
        bus.delay_done = 1'b1;
        #1 check({tag, "_wait1"}, C_ED, S_MVW);
        @(negedge clk);
        bus.delay_done = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        temp = 0;
        clk = 1'b0;
        reset_n = 1'b0;
        bus.decoded = I_ADDI | I_BR;
        bus.register0_is_zero = 1'b1;
        bus.temp_flags = 3'b111;
        bus.delay_done = 1'b1;

        @(negedge clk);
        #1 check("reset_a", 20'h0, S_FETCH);
        @(negedge clk);
        bus.decoded = I_PAUSE;
        #1 check("reset_b", 20'h0, S_FETCH);
        @(negedge clk);
        reset_n = 1'b1;
        bus.delay_done = 1'b0;
        temp = 0;
        set_flags();

        run_single("addi", I_ADDI, 1'b0, E_ADDI);
        run_single("subi", I_SUBI, 1'b0, E_SUBI);
        run_single("sr0", I_SR0, 1'b0, E_SR0);
        run_single("srh0", I_SRH0, 1'b0, E_SRH0);
        run_single("clr", I_CLR, 1'b0, E_CLR);
        run_single("mov", I_MOV, 1'b0, E_MOV);
        run_single("mova", I_MOVA, 1'b0, E_MOVA);
        run_single("br", I_BR, 1'b0, E_BR);
        run_single("brz_t", I_BRZ, 1'b1, E_BR);
        run_single("brz_n", I_BRZ, 1'b0, C_IPC);
        run_single("undec", 12'h000, 1'b1, C_IPC);
        run_single("multi", I_BR | I_ADDI, 1'b1, C_IPC);

        // movrhs of +3: one write per period, three periods
        bus.decoded = I_MOVRHS;
        #1 check("mvhs_fetch", 20'h0, S_FETCH);
        @(negedge clk);
        #1 check("mvhs_exec", C_LT, S_EXEC);
        @(negedge clk);
        temp = 3;
        mv_iter("mvhs1", 1);
        mv_iter("mvhs2", 1);
        mv_iter("mvhs3", 1);
        set_flags();
        #1 check("mvhs_done", C_IPC, S_CHK);
        @(negedge clk);

        // movr of -2: writes in pairs, subtracting
        bus.decoded = I_MOVR;
        #1 check("mvr_fetch", 20'h0, S_FETCH);
        @(negedge clk);
        #1 check("mvr_exec", C_LT, S_EXEC);
        @(negedge clk);
        temp = -2;
        mv_iter("mvr1", 2);
        mv_iter("mvr2", 2);
        set_flags();
        #1 check("mvr_done", C_IPC, S_CHK);
        @(negedge clk);

        // pause: delay_done on the start cycle must be ignored
        bus.decoded = I_PAUSE;
        #1 check("pause_fetch", 20'h0, S_FETCH);
        @(negedge clk);
        bus.delay_done = 1'b1;
        #1 check("pause_exec", C_SD, S_EXEC);
        @(negedge clk);
        bus.delay_done = 1'b0;
        #1 check("pause_w0", C_ED, S_WAITP);
        @(negedge clk);
        #1 check("pause_w1", C_ED, S_WAITP);
        @(negedge clk);
        bus.delay_done = 1'b1;
        #1 check("pause_done", C_ED | C_IPC, S_WAITP);
        @(negedge clk);
        bus.delay_done = 1'b0;

        // movr of +1 interrupted by reset in MV_WAIT
        bus.decoded = I_MOVR;
        #1 check("rst_fetch", 20'h0, S_FETCH);
        @(negedge clk);
        #1 check("rst_exec", C_LT, S_EXEC);
        @(negedge clk);
        temp = 1;
        set_flags();
        #1 check("rst_chk", 20'h0, S_CHK);
        @(negedge clk);
        #1 check("rst_step0", E_STEP, S_STEP);
        @(negedge clk);
        #1 check("rst_step1", E_STEP | C_DT | C_SD, S_STEP);
        @(negedge clk);
        temp = 0;
        set_flags();
        #1 check("rst_wait", C_ED, S_MVW);
        reset_n = 1'b0;
        #1 check("rst_async", 20'h0, S_FETCH);
        @(negedge clk);
        bus.delay_done = 1'b1;
        #1 check("rst_hold", 20'h0, S_FETCH);
        @(negedge clk);
        reset_n = 1'b1;
        bus.delay_done = 1'b0;
        run_single("after_rst", 12'h000, 1'b0, C_IPC);
        #1 check("after_rst_idle", 20'h0, S_FETCH);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Control FSM that drives the stepper-motor ASIP datapath.
- Each cycle it takes the decoded instruction flags and datapath status, and drives every datapath control input.
- Covers fetch wait, single-cycle ALU/branch instructions, multi-cycle relative motor moves (temp-register countdown plus delay counter per step) and pause.
- Instantiated beside the datapath at top level; purely control, no data operands.

Parameters:
FETCH_WAIT, 1, cycles spent in FETCH after a PC change (instruction ROM is synchronous, 1-cycle latency)
FULL_STEP_WRITES, 2, position writes per step period for movr (movrhs always 1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
decoded  in  12  {br,brz,addi,subi,sr0,srh0,clr,mov,mova,movr,movrhs,pause} one-hot from decoder; all-zero = undecoded
register0_is_zero  in  1  R0 == 0
temp_flags  in  3  {temp_is_positive,temp_is_negative,temp_is_zero}
delay_done  in  1  delay counter expired
write_reg_file  out  1  regfile write strobe
result_mux_select  out  1  0 = ALU result, 1 = constant 8'h00
op1_mux_select  out  2  0 pc, 1 selected0, 2 register0, 3 position
op2_mux_select  out  2  0 selected1, 1 immediate
alu_add_sub  out  1  0 add, 1 subtract
alu_set_low / alu_set_high  out  1 each  nibble insert; both high = pass operandb
select_immediate  out  2  0 sign-ext branch offset, 1 3-bit unsigned, 2 4-bit nibble, 3 constant 8'h01
select_write_address  out  2  0 field0, 1 field1, 2 POSITION_ADDR, 3 R0_ADDR
commit_branch / increment_pc  out  1 each  PC load from ALU / PC+1
load_temp / increment_temp / decrement_temp  out  1 each  temp register ops
start_delay_counter / enable_delay_counter  out  1 each  delay counter control
state_dbg  out  3  current state encoding

Behaviour:
- Async reset: state FETCH, wait counter loaded with FETCH_WAIT, step-write counter 0. All control outputs are decoded from state and are 0 while reset_n is low.
- Outputs are Moore plus the decoded flags; no output is registered separately. instruction_out stays stable during multi-cycle ops because PC is held.
- FETCH: all outputs 0. Count FETCH_WAIT cycles, then go to EXEC.
- EXEC, single-cycle ops. Each ends with increment_pc=1 and returns to FETCH, unless noted:
  - addi/subi: op1=1, op2=1, imm=1, add_sub=subi, write field0.
  - sr0/srh0: op1=2, op2=1, imm=2, set_low resp. set_high, write R0_ADDR.
  - clr: result_mux_select=1, write field0.
  - mov: op2=0, set_low=set_high=1, write field0.
  - mova: op2=0, pass, write POSITION_ADDR (absolute jump).
  - br: op1=0, op2=1, imm=0, add, commit_branch=1, increment_pc=0.
  - brz: same as br if register0_is_zero, else increment_pc only.
  - undecoded (all-zero) or multiple flags set: treated as NOP, increment_pc only.
  - pause: start_delay_counter=1, go to WAIT_P.
  - movr/movrhs: load_temp=1 (temp <= field0 register, signed), go to MV_CHECK.
- WAIT_P: enable_delay_counter=1. On delay_done: increment_pc, go to FETCH.
- MV_CHECK:
  - temp_is_zero: increment_pc, go to FETCH.
  - Otherwise load step-write counter (FULL_STEP_WRITES for movr, 1 for movrhs) and go to MV_STEP.
- MV_STEP: op1=3, op2=1, imm=3, add_sub = temp_is_negative, write POSITION_ADDR.
  - Decrement the step-write counter.
  - On the last write of the period: decrement_temp if positive, increment_temp if negative, start_delay_counter=1, go to MV_WAIT.
  - Otherwise stay in MV_STEP.
- MV_WAIT: enable_delay_counter=1. On delay_done, go to MV_CHECK.
- delay_done is ignored outside WAIT_P and MV_WAIT, including the start cycle.
- Delay register = 0: the sequencer still waits for delay_done (no bypass).
- Position wraps modulo 256. The stepper ROM uses position[2:0], so wrap is seamless.
- At most one of increment_pc / commit_branch per cycle. Never increment_temp and decrement_temp together. write_reg_file is never asserted in FETCH or wait states.
- Reset mid-move: FSM returns to FETCH immediately. The motor holds its last position and temp is cleared by its own reset.

Decomposition:
- Package seq_pkg holds:
  - state enum;
  - OP1_/OP2_/IMM_/WADDR_ select constants;
  - decoded-bit index constants;
  - POSITION_ADDR = 2'd2, R0_ADDR = 2'd0.
- Single module; no sub-module. The step-write counter is a 2-bit register inside.

Test Plan:
- Reset: hold reset_n=0 with arbitrary inputs -> all outputs 0, state_dbg=FETCH; after release the first EXEC occurs on the 2nd cycle.
- addi: decoded=addi -> one EXEC cycle with write_reg_file=1, op1=1, op2=1, imm=1, add_sub=0, increment_pc=1, then FETCH.
- brz: register0_is_zero=1 -> commit_branch=1, increment_pc=0. With 0 -> increment_pc=1, commit_branch=0.
- movrhs, temp=+3 ramp, delay_done two cycles after each start -> exactly 3 position writes with add_sub=0 and 3 decrement_temp pulses, each separated by MV_WAIT. PC advances only after temp_is_zero.
- movr, temp=-2 -> 4 position writes with add_sub=1, in pairs on consecutive cycles, and 2 increment_temp pulses.
- pause plus reset_n pulsed low during MV_WAIT of a movr -> pause holds PC until delay_done, then increment_pc. The movr returns to FETCH with all outputs 0 and no further position write.
